// File: rtl/usb_rx_pkg.sv
// Shared types for the USB RX packet read controller.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StStream,
        StFlush,
        StDone
    } rx_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE = 2'd0;
    localparam err_code_t ERR_PID  = 2'd1;
    localparam err_code_t ERR_LINE = 2'd2;
    localparam err_code_t ERR_OVF  = 2'd3;

endpackage

// File: rtl/usb_rx_packet_ctrl_if.sv
// FIFO-side, consumer-side and status signals of the RX packet controller.
interface usb_rx_packet_ctrl_if #(
    parameter int unsigned MAX_BYTES = 64
) ();
    import usb_rx_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    logic [7:0]       r_data;
    logic             empty;
    logic             rcving;
    logic             r_error;
    logic             r_enable;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             pkt_done;
    logic             pkt_err;
    err_code_t        err_code;
    logic [3:0]       pid;
    logic [CNT_W-1:0] byte_count;

    modport master (
        input  r_data, empty, rcving, r_error, out_ready,
        output r_enable, out_data, out_valid, out_last,
               pkt_done, pkt_err, err_code, pid, byte_count
    );

    modport slave (
        output r_data, empty, rcving, r_error, out_ready,
        input  r_enable, out_data, out_valid, out_last,
               pkt_done, pkt_err, err_code, pid, byte_count
    );

endinterface

// File: rtl/usb_pid_check.sv
// A PID byte is valid when its upper nibble is the complement of its lower nibble.
module usb_pid_check (
    input  logic [7:0] pid_byte,
    output logic       pid_ok
);

    assign pid_ok = (pid_byte[7:4] == ~pid_byte[3:0]);

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// Drains the receiver FIFO packet by packet: PID check, byte streaming with end marker,
// and per-packet status.
module usb_rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64
) (
    input logic                  clk,
    input logic                  n_rst,
    usb_rx_packet_ctrl_if.master bus
);

    localparam int unsigned     CNT_W   = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

    rx_state_t        state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       pid_q, pid_d;
    err_code_t        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_err_q;

    logic pid_ok;
    logic at_max;
    logic r_enable, out_valid, out_last;

    usb_pid_check u_pid_check (
        .pid_byte (bus.r_data),
        .pid_ok   (pid_ok)
    );

    assign at_max = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pid_d     = pid_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        r_enable  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            StIdle: begin
                if (!bus.empty) begin
                    r_enable = 1'b1;
                    pid_d    = bus.r_data[3:0];
                    cnt_d    = '0;
                    if (pid_ok) begin
                        err_d   = ERR_NONE;
                        state_d = StFill;
                    end else begin
                        err_d   = ERR_PID;
                        state_d = StFlush;
                    end
                end
            end
            StFill: begin
                if (bus.r_error) begin
                    err_d   = ERR_LINE;
                    state_d = StFlush;
                end else if (!bus.empty) begin
                    if (at_max) begin
                        err_d   = ERR_OVF;
                        state_d = StFlush;
                    end else begin
                        r_enable = 1'b1;
                        hold_d   = bus.r_data;
                        cnt_d    = cnt_q + CNT_W'(1);
                        state_d  = StStream;
                    end
                end else if (!bus.rcving) begin
                    state_d = StDone;
                end
            end
            StStream: begin
                if (bus.r_error) begin
                    err_d   = ERR_LINE;
                    state_d = StFlush;
                end else if (!bus.empty && at_max) begin
                    // Another byte behind a full count: drop the held byte, never present it.
                    err_d   = ERR_OVF;
                    state_d = StFlush;
                end else begin
                    out_valid = !bus.empty || !bus.rcving;
                    out_last  = bus.empty && !bus.rcving;
                    if (out_valid && bus.out_ready) begin
                        if (out_last) begin
                            state_d = StDone;
                        end else begin
                            r_enable = 1'b1;
                            hold_d   = bus.r_data;
                            cnt_d    = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            StFlush: begin
                r_enable = !bus.empty;
                if (bus.empty && !bus.rcving) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            pid_q      <= '0;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pid_q      <= pid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            done_q     <= (state_d == StDone);
            done_err_q <= (state_d == StDone) && (err_d != ERR_NONE);
        end
    end

    // Gate the combinational strobes so nothing is popped or offered while held in reset.
    assign bus.r_enable   = r_enable & n_rst;
    assign bus.out_valid  = out_valid & n_rst;
    assign bus.out_last   = out_last & n_rst;
    assign bus.out_data   = hold_q;
    assign bus.pkt_done   = done_q;
    assign bus.pkt_err    = done_err_q;
    assign bus.err_code   = err_q;
    assign bus.pid        = pid_q;
    assign bus.byte_count = cnt_q;

endmodule

// File: doc/usb_rx_packet_ctrl.md
# usb_rx_packet_ctrl

Packet-level read controller that sits behind `usb_receiver` and drains its RX FIFO.

- Pops the PID byte and validates it, then streams the remaining packet bytes to a downstream consumer over a valid/ready handshake with an end-of-packet marker.
- Reports per-packet status (PID, byte count, error class) when each packet completes.
- Is the only block that drives `usb_receiver.r_enable`.

## Interface
Parameters:
- `MAX_BYTES`, 64: maximum data bytes after the PID. The packet that attempts the (MAX_BYTES+1)-th pop is an overflow.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, synchronous and active-low.
- `r_data`  in  8  head byte of the RX FIFO; valid whenever `empty`=0.
- `empty`  in  1  RX FIFO empty.
- `rcving`  in  1  receiver is inside a packet.
- `r_error`  in  1  receiver line/framing error.
- `r_enable`  out  1  pops the FIFO head on this clock edge; never asserted while `empty`=1.
- `out_data`  out  8  data byte to the consumer.
- `out_valid`  out  1  `out_data`/`out_last` are valid.
- `out_last`  out  1  final data byte of the packet.
- `out_ready`  in  1  consumer accepts the byte.
- `pkt_done`  out  1  one-cycle pulse at packet completion.
- `pkt_err`  out  1  high with `pkt_done` when `err_code`≠0.
- `err_code`  out  2  0 OK, 1 bad PID, 2 line error, 3 overflow.
- `pid`  out  4  low nibble of the last accepted PID byte.
- `byte_count`  out  $clog2(MAX_BYTES+1)  data bytes popped in the current/last packet.

## Operation
- States: IDLE, FILL, STREAM, FLUSH, DONE. A one-byte hold register buffers the current data byte.
- **IDLE:** when `empty`=0, pop the PID byte, latch `pid`, clear `byte_count`, clear `err_code`.
  - If `r_data[7:4]` == ~`r_data[3:0]`, go to FILL.
  - Otherwise set `err_code`=1 and go to FLUSH.
- **FILL** (hold empty):
  - If `empty`=0, pop into hold, increment `byte_count`, go to STREAM.
  - If `empty`=1 and `rcving`=0, go to DONE (PID-only packet, OK).
- **STREAM** (hold full): `out_data`=hold. `out_valid` is asserted only when lastness is known:
  - `empty`=0: `out_last`=0.
  - `empty`=1 and `rcving`=0: `out_last`=1.
  - `empty`=1 and `rcving`=1: `out_valid`=0; wait.
- **STREAM transfer** (`out_valid`&&`out_ready`):
  - If `out_last`=1, go to DONE.
  - Otherwise pop the next byte into hold in the same cycle and increment `byte_count`.
- **Overflow:** a pop that would make `byte_count` exceed MAX_BYTES does not happen. Instead set `err_code`=3 and go to FLUSH. The held byte is discarded with no `out_last`.
- **Line error:** `r_error`=1 in FILL or STREAM forces `out_valid`=0, sets `err_code`=2 and goes to FLUSH. This has priority over a same-cycle transfer, pop or overflow.
- **FLUSH:** `r_enable`=~`empty`; no output. When `empty`=1 and `rcving`=0, go to DONE.
- **DONE:** `pkt_done`=1 for exactly one cycle, `pkt_err`=(`err_code`≠0), then go to IDLE.
- `pid`, `err_code` and `byte_count` hold their values until the next PID pop.
- `r_error` is ignored in IDLE, FLUSH and DONE.

## Timing
- Reset (`n_rst`=0 at a rising edge) forces state IDLE, hold cleared, and all outputs 0. This applies mid-packet too: the partial packet is abandoned with no `pkt_done`.
- After reset, bytes still in the FIFO are treated as a new packet starting with a PID.
- The receiver writes a packet's final byte at least one cycle before `rcving` falls, so `empty`=1 with `rcving`=0 means the packet is fully drained.
- `r_enable`, `out_valid` and `out_last` are combinational from state and inputs; all status outputs are registered.
- Latency:
  - PID pop to first `out_valid`: 2 cycles minimum (PID pop, FILL pop, STREAM valid).
  - With `out_ready` held high, throughput is 1 byte/cycle.
- The consumer may hold `out_ready` low indefinitely; the byte and `out_last` stay stable while `out_valid`=1 and no error occurs.
- The same cycle as `pkt_done` never carries a transfer.

## Structure
- Package `usb_rx_pkg`: state enum `rx_state_t`; `err_code_t` constants `ERR_NONE`, `ERR_PID`, `ERR_LINE`, `ERR_OVF`.
- Optional combinational sub-module `usb_pid_check` (8-bit byte in, valid out). Everything else is one FSM module.

## Test plan
- PID 0xC3 then data 0x11,0x22,0x33, `out_ready`=1 -> three transfers, `out_last` only on 0x33; `pkt_done`=1, `pkt_err`=0, `pid`=3, `byte_count`=3.
- PID 0xC4 (invalid) then 0xAA,0xBB -> no `out_valid`; FIFO drained; `err_code`=1, `pkt_err`=1.
- `r_error` rises after 0x11 has been accepted, while 0x22 is in hold -> 0x22 never presented; flush; `err_code`=2, `byte_count`=2.
- MAX_BYTES=4, packet of 6 data bytes -> 0x01–0x03 transferred without `out_last`; `err_code`=3; FIFO empty at DONE.
- `out_ready` low for 10 cycles during STREAM -> `out_data`/`out_last` stable, no pops; on release all bytes are delivered in order.
- PID-only packet 0x5A -> no `out_valid`; `pkt_done` with `byte_count`=0, `pid`=0xA, OK. Also: `n_rst` low mid-STREAM -> all outputs 0 the next cycle.
